dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory controller between the processor's DMEM port and a word-wide, variable-latency data SRAM.
- Accepts one load/store request at a time and returns a response pulse.
- Performs big-endian byte/half-word lane selection, load sign/zero extension, and read-modify-write for sub-word stores.
- Flags misaligned accesses and memory timeouts; a stall signal (req_ready low) holds the core while busy.

Parameters:
- TIMEOUT_CYCLES, 255: cycles mem_req may stay high without mem_ack before the access aborts with error (1..255).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  processor request present
- req_ready  out  1  controller idle, request accepted this cycle if req_valid
- req_addr  in  32 [0:31]  byte address; bit 31 is LSB
- req_we  in  1  1 = store, 0 = load
- req_byte  in  1  byte access (overrides req_half_word)
- req_half_word  in  1  half-word access
- req_sign_extend  in  1  sign-extend sub-word load; else zero-extend
- req_wdata  in  32 [0:31]  store data, right-justified in bits [24:31] (byte) or [16:31] (half)
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_data  out  32 [0:31]  load result, valid with resp_valid; 0 for stores and errors
- resp_error  out  1  with resp_valid: misaligned or timeout
- mem_req  out  1  SRAM access request
- mem_we  out  1  SRAM write
- mem_addr  out  30 [0:29]  word address = req_addr[0:29]
- mem_wdata  out  32 [0:31]  SRAM write word
- mem_rdata  in  32 [0:31]  SRAM read word, valid when mem_ack=1 and mem_we=0
- mem_ack  in  1  SRAM completes the current request this cycle

Behaviour:
- Reset (reset=0, async): state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_error=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout counter=0. Reset mid-access drops mem_req immediately; no response is issued.
- Request capture: on a clock edge with req_valid & req_ready, all req_* fields are registered. Later changes on req_* are ignored until the next acceptance.
- Lane mapping (big-endian): offset = addr[30:31].
  - Byte k occupies bits [8k:8k+7].
  - Half at offset 0 occupies [0:15]; at offset 2 occupies [16:31].
- Alignment:
  - Half-word requires addr[31]=0.
  - Word requires addr[30:31]=00.
  - Byte is always aligned.
- States:
  - IDLE: req_ready=1. On accept:
    - misaligned -> ERR
    - load or word store -> RD if load, WR if word store
    - sub-word store -> RMW_RD
  - RD: mem_req=1, mem_we=0. On mem_ack, latch mem_rdata and extract the lane, then -> RESP.
  - RMW_RD: same as RD, but on mem_ack compute merged = mem_rdata with the addressed lane replaced by store data, then -> WR.
  - WR: mem_req=1, mem_we=1, mem_wdata = full word or merged. On mem_ack -> RESP.
  - ERR: -> RESP with error, no SRAM access.
  - RESP: resp_valid=1 for exactly one cycle, then -> IDLE. req_ready=0 in every state except IDLE.
- Mem handshake: mem_addr, mem_we and mem_wdata are stable while mem_req=1. mem_req deasserts the cycle after mem_ack is sampled. mem_ack while mem_req=0 is ignored.
- Latency from the accept edge, with mem_ack returned in the same cycle as mem_req:
  - load and word store: resp_valid on cycle +2
  - sub-word store: cycle +3
  - misaligned: cycle +2
  - Each wait cycle of mem_ack adds 1.
- Load extension: the byte or half lane is right-justified. Upper bits are filled with the lane MSB if req_sign_extend=1, else 0. Word loads ignore req_sign_extend.
- Timeout:
  - The counter clears on entering RD, RMW_RD or WR and increments each cycle mem_req=1 & mem_ack=0.
  - When it reaches TIMEOUT_CYCLES: mem_req drops next cycle, -> RESP with resp_error=1, resp_data=0.
  - A timeout in RMW_RD aborts without any write.
- resp_error=1 never coincides with any SRAM write for that request.

Test Plan:
- Word load, SRAM word 0x40 = 0x11223344, immediate ack, addr=0x40:
  - mem_req on cycle +1 with mem_addr=0x10.
  - resp_valid on cycle +2 with resp_data=0x11223344.
  - req_ready=0 during cycles +1..+2.
- Byte load sign/zero, same word, addr=0x43:
  - sign_extend=1 -> 0x00000044.
  - Word 0x112233F4, addr 0x43, sign_extend=1 -> 0xFFFFFFF4.
  - Same with sign_extend=0 -> 0x000000F4.
- Half store RMW, word 0x11223344, addr=0x42, wdata=0x0000ABCD:
  - Read cycle, then write cycle with mem_wdata=0x1122ABCD.
  - resp_valid on cycle +3 with resp_error=0.
- Misaligned, half load addr=0x41 or word store addr=0x42:
  - mem_req never asserts.
  - resp_valid=1, resp_error=1, resp_data=0 on cycle +2.
- Timeout, TIMEOUT_CYCLES=4, mem_ack held 0 on a byte store:
  - mem_req high 4 cycles, then drops.
  - resp_error=1; mem_we never asserted.
  - Next request is accepted normally.
- Wait states and reset: word load with mem_ack delayed 3 cycles -> resp_valid on cycle +5. Repeat, and drive reset=0 mid-RD -> mem_req=0 immediately, req_ready=1 after release, no resp_valid.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Bundle of the core-side DMEM request/response port and the SRAM port of dmem_ctrl.
// 'slave' is the controller's view; 'master' is the environment (core + SRAM) view.
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [0:31] req_addr;
  logic        req_we;
  logic        req_byte;
  logic        req_half_word;
  logic        req_sign_extend;
  logic [0:31] req_wdata;
  logic        resp_valid;
  logic [0:31] resp_data;
  logic        resp_error;
  logic        mem_req;
  logic        mem_we;
  logic [0:29] mem_addr;
  logic [0:31] mem_wdata;
  logic [0:31] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  req_valid, req_addr, req_we, req_byte, req_half_word, req_sign_extend, req_wdata,
    input  mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_data, resp_error,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_we, req_byte, req_half_word, req_sign_extend, req_wdata,
    output mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_data, resp_error,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Single-outstanding load/store controller between the core DMEM port and a word-wide,
// variable-latency SRAM: big-endian lane select, load extension, RMW sub-word stores, timeout.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic        i_clock,
  input logic        i_reset,
  dmem_ctrl_if.slave io_bus
);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_ERR,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_error;
  logic [0:31] r_resp_data;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [0:29] r_mem_addr;
  logic [0:31] r_mem_wdata;
  logic        r_byte;
  logic        r_half;
  logic        r_sext;
  logic [1:0]  r_off;
  logic [0:31] r_wdata;
  logic [7:0]  r_tmo_cnt;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_is_word;
  logic        w_timeout;
  logic [1:0]  w_req_off;
  logic [0:31] w_load_data;
  logic [0:31] w_merged;

  // Lane k of a big-endian word sits at bits [8k:8k+7]; result is right-justified.
  function automatic logic [0:31] extract_lane(input logic [0:31] word, input logic [1:0] off,
                                               input logic is_byte, input logic is_half,
                                               input logic sext);
    logic [0:7]  b;
    logic [0:15] h;
    logic [0:31] res;
    // NOTE: every local gets a value on every path before use, so nothing holds state.
    unique case (off)
      2'd0:    b = word[0:7];
      2'd1:    b = word[8:15];
      2'd2:    b = word[16:23];
      default: b = word[24:31];
    endcase
    h   = off[1] ? word[16:31] : word[0:15];
    res = word;
    if (is_byte)      res = sext ? {{24{b[0]}}, b} : {24'h0, b};
    else if (is_half) res = sext ? {{16{h[0]}}, h} : {16'h0, h};
    return res;
  endfunction

  function automatic logic [0:31] merge_lane(input logic [0:31] word, input logic [1:0] off,
                                             input logic is_byte, input logic [0:31] wdata);
    logic [0:31] res;
    res = word;
    if (is_byte) begin
      unique case (off)
        2'd0:    res[0:7]   = wdata[24:31];
        2'd1:    res[8:15]  = wdata[24:31];
        2'd2:    res[16:23] = wdata[24:31];
        default: res[24:31] = wdata[24:31];
      endcase
    end else if (off[1]) begin
      res[16:31] = wdata[16:31];
    end else begin
      res[0:15] = wdata[16:31];
    end
    return res;
  endfunction

  assign w_req_off    = io_bus.req_addr[30:31];
  assign w_accept     = io_bus.req_valid & r_req_ready;
  assign w_is_word    = ~io_bus.req_byte & ~io_bus.req_half_word;
  assign w_misaligned = ~io_bus.req_byte &
                        (io_bus.req_half_word ? io_bus.req_addr[31] : (w_req_off != 2'b00));
  assign w_timeout    = (r_tmo_cnt == TMO_LAST);
  assign w_load_data  = extract_lane(io_bus.mem_rdata, r_off, r_byte, r_half, r_sext);
  assign w_merged     = merge_lane(io_bus.mem_rdata, r_off, r_byte, r_wdata);

  // NOTE: all state and outputs are registered here with non-blocking assignments so every
  // reader sees the pre-edge value, independent of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_data  <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_byte       <= 1'b0;
      r_half       <= 1'b0;
      r_sext       <= 1'b0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_byte      <= io_bus.req_byte;
            r_half      <= io_bus.req_half_word & ~io_bus.req_byte;
            r_sext      <= io_bus.req_sign_extend;
            r_off       <= w_req_off;
            r_wdata     <= io_bus.req_wdata;
            r_mem_addr  <= io_bus.req_addr[0:29];
            r_tmo_cnt   <= '0;
            if (w_misaligned) begin
              r_state <= S_ERR;
            end else if (!io_bus.req_we) begin
              r_state   <= S_RD;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
            end else if (w_is_word) begin
              r_state     <= S_WR;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= io_bus.req_wdata;
            end else begin
              r_state   <= S_RMW_RD;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
            end
          end
        end

        S_RD, S_RMW_RD, S_WR: begin
          if (io_bus.mem_ack) begin
            r_tmo_cnt <= '0;
            if (r_state == S_RMW_RD) begin
              // Write phase follows the read back-to-back, so mem_req stays high.
              r_state     <= S_WR;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= w_merged;
            end else begin
              r_state      <= S_RESP;
              r_mem_req    <= 1'b0;
              r_mem_we     <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp_data  <= (r_state == S_RD) ? w_load_data : '0;
            end
          end else if (w_timeout) begin
            r_state      <= S_RESP;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b1;
            r_resp_data  <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end

        S_ERR: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_error <= 1'b1;
          r_resp_data  <= '0;
        end

        S_RESP: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_error <= 1'b0;
          r_resp_data  <= '0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.req_ready  = r_req_ready;
  assign io_bus.resp_valid = r_resp_valid;
  assign io_bus.resp_error = r_resp_error;
  assign io_bus.resp_data  = r_resp_data;
  assign io_bus.mem_req    = r_mem_req;
  assign io_bus.mem_we     = r_mem_we;
  assign io_bus.mem_addr   = r_mem_addr;
  assign io_bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: a word-array SRAM responder with programmable wait
// states, and a byte-addressed big-endian reference model for expected results.
module tb_dmem_ctrl;
  localparam int TMO = 4;

  logic clock;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  dmem_ctrl_if io ();

  dmem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clock (clock),
    .i_reset (reset_n),
    .io_bus  (io)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // SRAM responder (environment side)
  logic [31:0] sram [16];
  int  ack_delay    = 0;
  bit  ack_enable   = 1'b1;
  bit  spurious_ack = 1'b0;
  int  wait_cnt     = 0;
  int  wr_count     = 0;

  always @(negedge clock) begin
    if (io.mem_req && ack_enable && wait_cnt >= ack_delay) begin
      io.mem_ack   = 1'b1;
      io.mem_rdata = sram[io.mem_addr[26:29]];
    end else begin
      io.mem_ack   = spurious_ack && !io.mem_req;
      io.mem_rdata = $urandom;
    end
  end

  always @(posedge clock) begin
    if (io.mem_req && io.mem_ack) begin
      wait_cnt = 0;
      if (io.mem_we) begin
        sram[io.mem_addr[26:29]] = io.mem_wdata;
        wr_count++;
      end
    end else if (io.mem_req) begin
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
  end

  // Reference model: memory as a flat big-endian byte array (byte address a -> mb[a]).
  logic [7:0] mb [64];

  task automatic set_word(input int idx, input logic [31:0] val);
    sram[idx] = val;
    for (int k = 0; k < 4; k++) mb[4*idx + k] = val[31-8*k -: 8];
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return {mb[4*idx], mb[4*idx+1], mb[4*idx+2], mb[4*idx+3]};
  endfunction

  function automatic logic [31:0] model_load(input int a, input logic byt, input logic half,
                                             input logic sext);
    logic [15:0] h;
    if (byt) return sext ? {{24{mb[a][7]}}, mb[a]} : {24'h0, mb[a]};
    if (half) begin
      h = {mb[a], mb[a+1]};
      return sext ? {{16{h[15]}}, h} : {16'h0, h};
    end
    return {mb[a], mb[a+1], mb[a+2], mb[a+3]};
  endfunction

  task automatic model_store(input int a, input logic byt, input logic half,
                             input logic [31:0] wdata);
    if (byt) begin
      mb[a] = wdata[7:0];
    end else if (half) begin
      mb[a]   = wdata[15:8];
      mb[a+1] = wdata[7:0];
    end else begin
      for (int k = 0; k < 4; k++) mb[a+k] = wdata[31-8*k -: 8];
    end
  endtask

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic        err;
    int          mreq_cycles;
    logic        we_seen;
    logic [29:0] first_addr;
    logic        ready_low_ok;
    logic        addr_stable;
    logic        pulse_ok;
    logic        timed_out;
  } obs_t;

  // Issues one request and records what the DUT does; cycle +k is the k-th cycle after accept.
  task automatic do_req(input logic we, input logic byt, input logic half, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata, output obs_t o);
    int  n;
    bit  found;
    o = '{default: '0};
    n = 0;
    while (!io.req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!io.req_ready) begin
      o.timed_out = 1'b1;
      return;
    end
    io.req_valid = 1'b1; io.req_we = we; io.req_byte = byt; io.req_half_word = half;
    io.req_sign_extend = sext; io.req_addr = addr; io.req_wdata = wdata;
    @(posedge clock);
    #1;
    io.req_valid = 1'b0; io.req_we = $urandom; io.req_byte = $urandom;
    io.req_half_word = $urandom; io.req_sign_extend = $urandom;
    io.req_addr = $urandom; io.req_wdata = $urandom;
    o.ready_low_ok = 1'b1;
    o.addr_stable  = 1'b1;
    found = 1'b0;
    for (int c = 1; c <= 60 && !found; c++) begin
      @(negedge clock);
      if (io.req_ready) o.ready_low_ok = 1'b0;
      if (io.mem_req) begin
        if (o.mreq_cycles == 0) o.first_addr = io.mem_addr;
        else if (io.mem_addr !== o.first_addr) o.addr_stable = 1'b0;
        o.mreq_cycles++;
      end
      if (io.mem_we) o.we_seen = 1'b1;
      if (io.resp_valid) begin
        found  = 1'b1;
        o.lat  = c;
        o.data = io.resp_data;
        o.err  = io.resp_error;
      end
    end
    if (!found) begin
      o.timed_out = 1'b1;
      return;
    end
    @(negedge clock);
    o.pulse_ok = !io.resp_valid && io.req_ready && (io.resp_data === 32'h0);
  endtask

  task automatic test_reset();
    checks++; if (io.req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b want 1", io.req_ready); end
    checks++; if (io.resp_valid !== 1'b0 || io.resp_error !== 1'b0) begin errors++; $display("FAIL reset resp: got valid=%b err=%b want 0/0", io.resp_valid, io.resp_error); end
    checks++; if (io.resp_data !== 32'h0) begin errors++; $display("FAIL reset resp_data: got %h want 0", io.resp_data); end
    checks++; if (io.mem_req !== 1'b0 || io.mem_we !== 1'b0) begin errors++; $display("FAIL reset mem ctl: got req=%b we=%b want 0/0", io.mem_req, io.mem_we); end
    checks++; if (io.mem_addr !== 30'h0 || io.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset mem bus: got addr=%h wdata=%h want 0/0", io.mem_addr, io.mem_wdata); end
    spurious_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++; if (io.mem_req !== 1'b0 || io.resp_valid !== 1'b0 || io.req_ready !== 1'b1) begin errors++; $display("FAIL idle_ack[%0d]: got req=%b resp=%b ready=%b want 0/0/1", i, io.mem_req, io.resp_valid, io.req_ready); end
    end
    spurious_ack = 1'b0;
  endtask

  typedef struct {
    logic we, byt, half, sext;
    logic [31:0] addr, wdata, pre, exp_data, exp_word;
    int exp_lat, exp_mreq;
    logic exp_err;
  } dir_t;

  task automatic test_directed();
    dir_t t [10];
    obs_t o;
    int   idx;
    t[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0,        32'h11223344, 32'h11223344, 32'h11223344, 2, 1, 1'b0};
    t[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h43, 32'h0,        32'h11223344, 32'h00000044, 32'h11223344, 2, 1, 1'b0};
    t[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h43, 32'h0,        32'h112233F4, 32'hFFFFFFF4, 32'h112233F4, 2, 1, 1'b0};
    t[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h43, 32'h0,        32'h112233F4, 32'h000000F4, 32'h112233F4, 2, 1, 1'b0};
    t[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h42, 32'h0000ABCD, 32'h11223344, 32'h0,        32'h1122ABCD, 3, 2, 1'b0};
    t[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h41, 32'h0,        32'h11223344, 32'h0,        32'h11223344, 2, 0, 1'b1};
    t[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h42, 32'hDEADBEEF, 32'h11223344, 32'h0,        32'h11223344, 2, 0, 1'b1};
    t[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0,        32'h80012345, 32'hFFFF8001, 32'h80012345, 2, 1, 1'b0};
    t[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h41, 32'hFFFFFF77, 32'h11223344, 32'h0,        32'h11773344, 3, 2, 1'b0};
    t[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'hCAFEF00D, 32'h11223344, 32'h0,        32'hCAFEF00D, 2, 1, 1'b0};
    ack_delay = 0;
    for (int i = 0; i < 10; i++) begin
      idx = int'(t[i].addr[5:2]);
      set_word(idx, t[i].pre);
      do_req(t[i].we, t[i].byt, t[i].half, t[i].sext, t[i].addr, t[i].wdata, o);
      checks++; if (o.timed_out) begin errors++; $display("FAIL dir[%0d] response: got none want resp_valid", i); continue; end
      checks++; if (o.lat != t[i].exp_lat) begin errors++; $display("FAIL dir[%0d] latency: got %0d want %0d", i, o.lat, t[i].exp_lat); end
      checks++; if (o.data !== t[i].exp_data || o.err !== t[i].exp_err) begin errors++; $display("FAIL dir[%0d] resp: got data=%h err=%b want %h/%b", i, o.data, o.err, t[i].exp_data, t[i].exp_err); end
      checks++; if (o.mreq_cycles != t[i].exp_mreq) begin errors++; $display("FAIL dir[%0d] mem_req cycles: got %0d want %0d", i, o.mreq_cycles, t[i].exp_mreq); end
      checks++; if (sram[idx] !== t[i].exp_word) begin errors++; $display("FAIL dir[%0d] sram word: got %h want %h", i, sram[idx], t[i].exp_word); end
      checks++; if (!o.ready_low_ok || !o.pulse_ok) begin errors++; $display("FAIL dir[%0d] handshake: got ready_low=%b pulse=%b want 1/1", i, o.ready_low_ok, o.pulse_ok); end
      if (t[i].exp_mreq > 0) begin
        checks++; if (o.first_addr !== t[i].addr[31:2]) begin errors++; $display("FAIL dir[%0d] mem_addr: got %h want %h", i, o.first_addr, t[i].addr[31:2]); end
      end
    end
  endtask

  task automatic test_random();
    obs_t        o;
    logic        we, byt, half, sext, mis, word;
    logic [31:0] addr, wdata, exp_data;
    int          d, exp_lat, exp_mreq, a;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    for (int i = 0; i < 80; i++) begin
      we = $urandom; byt = ($urandom_range(0, 2) == 0); half = $urandom; sext = $urandom;
      addr = $urandom; wdata = $urandom; d = $urandom_range(0, 2);
      ack_delay = d;
      a    = int'(addr[5:0]);
      word = !byt && !half;
      mis  = !byt && (half ? addr[0] : (addr[1:0] != 2'b00));
      exp_data = 32'h0;
      if (mis) begin
        exp_lat = 2; exp_mreq = 0;
      end else if (!we) begin
        exp_data = model_load(a, byt, half && !byt, sext);
        exp_lat = 2 + d; exp_mreq = 1 + d;
      end else begin
        model_store(a, byt, half && !byt, wdata);
        exp_lat  = word ? 2 + d : 3 + 2 * d;
        exp_mreq = word ? 1 + d : 2 + 2 * d;
      end
      do_req(we, byt, half, sext, addr, wdata, o);
      checks++; if (o.timed_out) begin errors++; $display("FAIL rand[%0d] response: got none want resp_valid", i); continue; end
      checks++; if (o.lat != exp_lat) begin errors++; $display("FAIL rand[%0d] latency: got %0d want %0d", i, o.lat, exp_lat); end
      checks++; if (o.data !== exp_data || o.err !== mis) begin errors++; $display("FAIL rand[%0d] resp: got data=%h err=%b want %h/%b", i, o.data, o.err, exp_data, mis); end
      checks++; if (o.mreq_cycles != exp_mreq || o.we_seen !== (we && !mis)) begin errors++; $display("FAIL rand[%0d] mem ctl: got cycles=%0d we=%b want %0d/%b", i, o.mreq_cycles, o.we_seen, exp_mreq, we && !mis); end
      checks++; if (sram[addr[5:2]] !== model_word(int'(addr[5:2]))) begin errors++; $display("FAIL rand[%0d] sram word: got %h want %h", i, sram[addr[5:2]], model_word(int'(addr[5:2]))); end
      checks++; if (!o.ready_low_ok || !o.pulse_ok || !o.addr_stable) begin errors++; $display("FAIL rand[%0d] handshake: got ready_low=%b pulse=%b stable=%b want 1/1/1", i, o.ready_low_ok, o.pulse_ok, o.addr_stable); end
      if (exp_mreq > 0) begin
        checks++; if (o.first_addr !== addr[31:2]) begin errors++; $display("FAIL rand[%0d] mem_addr: got %h want %h", i, o.first_addr, addr[31:2]); end
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    int   wr_before;
    ack_enable = 1'b0;
    wr_before  = wr_count;
    do_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0045, 32'h0000_00AA, o);
    ack_enable = 1'b1;
    checks++; if (o.timed_out) begin errors++; $display("FAIL timeout response: got none want resp_valid"); end
    checks++; if (o.mreq_cycles != TMO) begin errors++; $display("FAIL timeout mem_req cycles: got %0d want %0d", o.mreq_cycles, TMO); end
    checks++; if (o.err !== 1'b1 || o.data !== 32'h0 || o.lat != TMO + 1) begin errors++; $display("FAIL timeout resp: got err=%b data=%h lat=%0d want 1/0/%0d", o.err, o.data, o.lat, TMO + 1); end
    checks++; if (o.we_seen !== 1'b0 || wr_count != wr_before) begin errors++; $display("FAIL timeout write: got we=%b writes=%0d want 0/%0d", o.we_seen, wr_count - wr_before, 0); end
    checks++; if (sram[1] !== model_word(1)) begin errors++; $display("FAIL timeout sram word: got %h want %h", sram[1], model_word(1)); end
    ack_delay = 0;
    do_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0, o);
    checks++; if (o.timed_out || o.err !== 1'b0 || o.data !== model_word(1) || o.lat != 2) begin errors++; $display("FAIL after_timeout load: got data=%h err=%b lat=%0d want %h/0/2", o.data, o.err, o.lat, model_word(1)); end
  endtask

  task automatic test_wait_reset();
    obs_t o;
    bit   resp_seen;
    ack_delay = 3;
    do_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0048, 32'h0, o);
    checks++; if (o.timed_out || o.lat != 5 || o.mreq_cycles != 4) begin errors++; $display("FAIL wait3 timing: got lat=%0d cycles=%0d want 5/4", o.lat, o.mreq_cycles); end
    checks++; if (o.data !== model_word(2) || o.err !== 1'b0) begin errors++; $display("FAIL wait3 data: got %h err=%b want %h/0", o.data, o.err, model_word(2)); end
    ack_enable = 1'b0;
    @(negedge clock);
    io.req_valid = 1'b1; io.req_we = 1'b0; io.req_byte = 1'b0; io.req_half_word = 1'b0;
    io.req_addr = 32'h0000_0048;
    @(posedge clock);
    #1 io.req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (io.mem_req !== 1'b1) begin errors++; $display("FAIL pre_reset mem_req: got %b want 1", io.mem_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (io.mem_req !== 1'b0 || io.req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset: got mem_req=%b ready=%b want 0/1", io.mem_req, io.req_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    ack_enable = 1'b1;
    resp_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (io.resp_valid || io.mem_req) resp_seen = 1'b1;
    end
    checks++; if (resp_seen || io.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset: got activity=%b ready=%b want 0/1", resp_seen, io.req_ready); end
    ack_delay = 1;
    do_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0048, 32'h0, o);
    checks++; if (o.timed_out || o.lat != 3 || o.data !== model_word(2)) begin errors++; $display("FAIL post_reset load: got lat=%0d data=%h want 3/%h", o.lat, o.data, model_word(2)); end
  endtask

  initial begin
    reset_n = 1'b0;
    io.req_valid = 1'b0; io.req_we = 1'b0; io.req_byte = 1'b0; io.req_half_word = 1'b0;
    io.req_sign_extend = 1'b0; io.req_addr = '0; io.req_wdata = '0;
    io.mem_ack = 1'b0; io.mem_rdata = '0;
    for (int i = 0; i < 16; i++) set_word(i, 32'h0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_wait_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
